// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect sequencer.
// Defines the state encodings, parameter defaults and the hold/flush bit order.
package pipe_ctrl_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int BUS_TIMEOUT_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_STALL = 2'd2,
    ST_BUS   = 2'd3
  } state_t;

  // Bit positions inside the packed stage-control vector
  localparam int CTL_HOLD_PC  = 0;
  localparam int CTL_HOLD_IF  = 1;
  localparam int CTL_HOLD_ID  = 2;
  localparam int CTL_FLUSH_IF = 3;
  localparam int CTL_FLUSH_ID = 4;
  localparam int CTL_W        = 5;

  localparam logic [CTL_W-1:0] CTL_HOLD_ALL  = 5'b00111;
  localparam logic [CTL_W-1:0] CTL_FLUSH_ALL = 5'b11000;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement and the
// count saturates at zero.
module pipe_ctrl_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and redirect sequencer for the IF/ID/EX core: merges redirect and stall
// requests into hold/flush controls. Optional bus watchdog: CTRL_BUS_TIMEOUT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int BUS_TIMEOUT  = BUS_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              int_req_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  input  logic              bus_hold_i,
  input  logic              div_busy_i,
  input  logic              ld_use_i,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              int_ack_o,
  output logic              hold_pc_o,
  output logic              hold_if_o,
  output logic              hold_id_o,
  output logic              flush_if_o,
  output logic              flush_id_o,
  output logic [1:0]        state_o,
  output logic              bus_err_o
);

  localparam int FC_W = cnt_w(FLUSH_CYCLES);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  if ((FLUSH_CYCLES < 1) || (BUS_TIMEOUT < 1)) begin : g_bad_param
    $error("pipe_ctrl: FLUSH_CYCLES and BUS_TIMEOUT must be >= 1");
  end

  state_t              state_reg, state_next;
  logic [CTL_W-1:0]    ctl;
  logic                redirect, ack, err;
  logic [ADDR_W-1:0]   addr;
  logic                fl_load, fl_dec, fl_zero;
  logic [FC_W-1:0]     fl_count;
  logic                tmo_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  pipe_ctrl_cnt #(.W(FC_W)) u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (fl_load),
    .load_val (FC_LOAD),
    .dec      (fl_dec),
    .count    (fl_count),
    .zero     (fl_zero)
  );

`ifdef CTRL_BUS_TIMEOUT_EN
  localparam int TO_W = cnt_w(BUS_TIMEOUT);
  logic [TO_W-1:0] tmo_val, tmo_count;
  logic            tmo_zero;

  // Preloaded on the way into BUS so expiry lands on the BUS_TIMEOUT-th BUS cycle
  assign tmo_val = (state_next == ST_BUS) ? TO_W'(BUS_TIMEOUT - 1) : '0;

  pipe_ctrl_cnt #(.W(TO_W)) u_tmo_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state_reg != ST_BUS),
    .load_val (tmo_val),
    .dec      (state_reg == ST_BUS),
    .count    (tmo_count),
    .zero     (tmo_zero)
  );

  assign tmo_expired = tmo_zero && (tmo_count == '0);
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ctl        = '0;
    redirect   = 1'b0;
    ack        = 1'b0;
    err        = 1'b0;
    addr       = jump_addr_i;
    fl_load    = 1'b0;
    fl_dec     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (int_req_i) begin
          redirect = 1'b1;
          ack      = 1'b1;
          addr     = int_addr_i;
        end else if (jump_en_i) begin
          redirect = 1'b1;
        end else if (bus_hold_i) begin
          ctl        = CTL_HOLD_ALL;
          state_next = ST_BUS;
        end else if (div_busy_i) begin
          ctl        = CTL_HOLD_ALL;
          state_next = ST_STALL;
        end else if (ld_use_i) begin
          ctl[CTL_HOLD_PC]  = 1'b1;
          ctl[CTL_HOLD_IF]  = 1'b1;
          ctl[CTL_FLUSH_ID] = 1'b1;
        end
      end
      ST_FLUSH: begin
        ctl    = CTL_FLUSH_ALL;
        fl_dec = 1'b1;
        // Interrupts wait here; only a fresh jump may re-redirect
        if (jump_en_i) redirect = 1'b1;
        else if (fl_zero || (fl_count == FC_W'(1))) state_next = ST_IDLE;
      end
      ST_STALL: begin
        if (div_busy_i) ctl = CTL_HOLD_ALL;
        else            state_next = ST_IDLE;
      end
      ST_BUS: begin
        if (bus_hold_i) begin
          if (tmo_expired) begin
            err        = 1'b1;
            state_next = ST_IDLE;
          end else begin
            ctl = CTL_HOLD_ALL;
          end
        end else if (div_busy_i) begin
          // Keep holds continuous across the BUS->STALL hand-off
          ctl        = CTL_HOLD_ALL;
          state_next = ST_STALL;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (redirect) begin
      ctl        = ctl | CTL_FLUSH_ALL;
      fl_load    = 1'b1;
      state_next = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
    end
  end

  // Reset forces every output low without waiting for a clock edge
  assign jump_en_o   = rst & redirect;
  assign int_ack_o   = rst & ack;
  assign bus_err_o   = rst & err;
  assign jump_addr_o = rst ? addr : '0;
  assign hold_pc_o   = rst & ctl[CTL_HOLD_PC];
  assign hold_if_o   = rst & ctl[CTL_HOLD_IF];
  assign hold_id_o   = rst & ctl[CTL_HOLD_ID];
  assign flush_if_o  = rst & ctl[CTL_FLUSH_IF];
  assign flush_id_o  = rst & ctl[CTL_FLUSH_ID];
  assign state_o     = state_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (FLUSH_CYCLES=2, BUS_TIMEOUT=16).
// Watchdog sequence runs only when CTRL_BUS_TIMEOUT_EN is defined.
module tb_pipe_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          jump_en_i = 1'b0;
  logic [AW-1:0] jump_addr_i = '0;
  logic          int_req_i = 1'b0;
  logic [AW-1:0] int_addr_i = '0;
  logic          bus_hold_i = 1'b0;
  logic          div_busy_i = 1'b0;
  logic          ld_use_i = 1'b0;
  logic          jump_en_o;
  logic [AW-1:0] jump_addr_o;
  logic          int_ack_o, hold_pc_o, hold_if_o, hold_id_o;
  logic          flush_if_o, flush_id_o, bus_err_o;
  logic [1:0]    state_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(2), .BUS_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_en_i   (jump_en_i),
    .jump_addr_i (jump_addr_i),
    .int_req_i   (int_req_i),
    .int_addr_i  (int_addr_i),
    .bus_hold_i  (bus_hold_i),
    .div_busy_i  (div_busy_i),
    .ld_use_i    (ld_use_i),
    .jump_en_o   (jump_en_o),
    .jump_addr_o (jump_addr_o),
    .int_ack_o   (int_ack_o),
    .hold_pc_o   (hold_pc_o),
    .hold_if_o   (hold_if_o),
    .hold_id_o   (hold_id_o),
    .flush_if_o  (flush_if_o),
    .flush_id_o  (flush_id_o),
    .state_o     (state_o),
    .bus_err_o   (bus_err_o)
  );

  typedef struct {
    string         name;
    logic          je;
    logic [AW-1:0] ja;
    logic          ir;
    logic [AW-1:0] ia;
    logic          bh, db, lu;
    logic [41:0]   exp;
  } vec_t;

  vec_t tbl[$];

  // Expected bundle: {jump_en, addr, ack, {hold_pc,hold_if,hold_id}, {flush_if,flush_id}, state, bus_err}
  function automatic logic [41:0] mk(input logic jeo, input logic [AW-1:0] jao, input logic ack,
                                     input logic [2:0] h, input logic [1:0] f, input logic [1:0] st,
                                     input logic err);
    return {jeo, jao, ack, h, f, st, err};
  endfunction

  function automatic logic [41:0] outs();
    return {jump_en_o, jump_addr_o, int_ack_o, hold_pc_o, hold_if_o, hold_id_o,
            flush_if_o, flush_id_o, state_o, bus_err_o};
  endfunction

  function automatic vec_t v(input string n, input logic je, input logic [AW-1:0] ja,
                             input logic ir, input logic [AW-1:0] ia,
                             input logic bh, input logic db, input logic lu,
                             input logic jeo, input logic [AW-1:0] jao, input logic ack,
                             input logic [2:0] h, input logic [1:0] f, input logic [1:0] st);
    vec_t r;
    r.name = n; r.je = je; r.ja = ja; r.ir = ir; r.ia = ia;
    r.bh = bh; r.db = db; r.lu = lu;
    r.exp = mk(jeo, jao, ack, h, f, st, 1'b0);
    return r;
  endfunction

  task automatic drive(input vec_t t);
    jump_en_i = t.je; jump_addr_i = t.ja; int_req_i = t.ir; int_addr_i = t.ia;
    bus_hold_i = t.bh; div_busy_i = t.db; ld_use_i = t.lu;
  endtask

  task automatic clear_inputs();
    jump_en_i = 0; jump_addr_i = '0; int_req_i = 0; int_addr_i = '0;
    bus_hold_i = 0; div_busy_i = 0; ld_use_i = 0;
  endtask

  task automatic check(input string n, input logic [41:0] exp);
    logic [41:0] act;
    act = outs();
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h (t=%0t)", n, act, exp, $time);
    end else begin
      $display("ok   %-12s out=%h", n, act);
    end
  endtask

  initial begin
    //                  name        je ja      ir ia     bh db lu  jeo jao     ack hold    flush   st
    tbl.push_back(v("idle",       0, 32'h44, 0, 32'h0,  0, 0, 0,  0, 32'h44, 0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("jmp_redir",  1, 32'h100,0, 32'h0,  0, 0, 0,  1, 32'h100,0, 3'b000, 2'b11, 2'd0));
    tbl.push_back(v("jmp_flush",  0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b11, 2'd1));
    tbl.push_back(v("jmp_done",   0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("int_jmp",    1, 32'h200,1, 32'h80, 0, 0, 0,  1, 32'h80, 1, 3'b000, 2'b11, 2'd0));
    tbl.push_back(v("int_noack",  0, 32'h0,  1, 32'h80, 0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b11, 2'd1));
    tbl.push_back(v("int_done",   0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("rej_a",      1, 32'h10, 0, 32'h0,  0, 0, 0,  1, 32'h10, 0, 3'b000, 2'b11, 2'd0));
    tbl.push_back(v("rej_b",      1, 32'h20, 0, 32'h0,  0, 0, 0,  1, 32'h20, 0, 3'b000, 2'b11, 2'd1));
    tbl.push_back(v("rej_fl",     0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b11, 2'd1));
    tbl.push_back(v("rej_done",   0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("lduse",      0, 32'h0,  0, 32'h0,  0, 0, 1,  0, 32'h0,  0, 3'b110, 2'b01, 2'd0));
    tbl.push_back(v("lduse_end",  0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("bd0",        0, 32'h0,  0, 32'h0,  1, 0, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd0));
    tbl.push_back(v("bd1",        0, 32'h0,  0, 32'h0,  1, 0, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd3));
    tbl.push_back(v("bd2",        0, 32'h0,  0, 32'h0,  1, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd3));
    tbl.push_back(v("bd3",        0, 32'h0,  0, 32'h0,  1, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd3));
    tbl.push_back(v("bd4",        0, 32'h0,  0, 32'h0,  0, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd3));
    tbl.push_back(v("bd5",        0, 32'h0,  0, 32'h0,  0, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd2));
    tbl.push_back(v("bd6",        0, 32'h0,  0, 32'h0,  0, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd2));
    tbl.push_back(v("bd7",        0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd2));
    tbl.push_back(v("bd8",        0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("bus_in",     0, 32'h0,  0, 32'h0,  1, 0, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd0));
    tbl.push_back(v("bus_rel",    0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd3));
    tbl.push_back(v("bus_idle",   0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("dv0",        0, 32'h0,  0, 32'h0,  0, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd0));
    tbl.push_back(v("dv1",        0, 32'h0,  0, 32'h0,  0, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd2));
    tbl.push_back(v("dv2_int",    0, 32'h0,  1, 32'h80, 0, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd2));
    tbl.push_back(v("dv3_int",    0, 32'h0,  1, 32'h80, 0, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd2));
    tbl.push_back(v("dv4_int",    0, 32'h0,  1, 32'h80, 0, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd2));
    tbl.push_back(v("dv5_rel",    0, 32'h0,  1, 32'h80, 0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd2));
    tbl.push_back(v("dv6_ack",    0, 32'h0,  1, 32'h80, 0, 0, 0,  1, 32'h80, 1, 3'b000, 2'b11, 2'd0));
    tbl.push_back(v("dv7_fl",     0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b11, 2'd1));
    tbl.push_back(v("dv8_idle",   0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("pri_jmp",    1, 32'h300,0, 32'h0,  1, 1, 1,  1, 32'h300,0, 3'b000, 2'b11, 2'd0));
    tbl.push_back(v("pri_jmp_fl", 0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b11, 2'd1));
    tbl.push_back(v("pri_jmp_id", 0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("pri_bus",    0, 32'h0,  0, 32'h0,  1, 1, 0,  0, 32'h0,  0, 3'b111, 2'b00, 2'd0));
    tbl.push_back(v("pri_bus_rl", 0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd3));
    tbl.push_back(v("pri_bus_id", 0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));
    tbl.push_back(v("pri_div",    0, 32'h0,  0, 32'h0,  0, 1, 1,  0, 32'h0,  0, 3'b111, 2'b00, 2'd0));
    tbl.push_back(v("pri_div_rl", 0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd2));
    tbl.push_back(v("pri_div_id", 0, 32'h0,  0, 32'h0,  0, 0, 0,  0, 32'h0,  0, 3'b000, 2'b00, 2'd0));

    // Reset holds every output low even with live requests on the inputs
    jump_en_i = 1; jump_addr_i = 32'h1234; int_req_i = 1; int_addr_i = 32'h80; ld_use_i = 1;
    #2;
    check("reset_state", '0);
    clear_inputs();
    #10 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check(tbl[i].name, tbl[i].exp);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a flush sequence
    jump_en_i = 1; jump_addr_i = 32'h100;
    @(posedge clk); #1;
    jump_en_i = 1; jump_addr_i = 32'h55; int_req_i = 1; int_addr_i = 32'h80; bus_hold_i = 1;
    #1;
    check("pre_rst", mk(1, 32'h55, 0, 3'b000, 2'b11, 2'd1, 0));
    #1 rst = 1'b0;
    #1;
    check("rst_async", '0);
    clear_inputs();
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst", mk(0, 32'h0, 0, 3'b000, 2'b00, 2'd0, 0));
    @(posedge clk); #1;
    jump_en_i = 1; jump_addr_i = 32'h104;
    @(negedge clk);
    check("rst_redir", mk(1, 32'h104, 0, 3'b000, 2'b11, 2'd0, 0));
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("rst_flush", mk(0, 32'h0, 0, 3'b000, 2'b11, 2'd1, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_idle", mk(0, 32'h0, 0, 3'b000, 2'b00, 2'd0, 0));

`ifdef CTRL_BUS_TIMEOUT_EN
    // Stuck bus grant: error pulse on the 16th BUS cycle, IDLE on the next
    @(posedge clk); #1;
    bus_hold_i = 1;
    @(negedge clk);
    check("to_enter", mk(0, 32'h0, 0, 3'b111, 2'b00, 2'd0, 0));
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k < 16) check($sformatf("to_bus%0d", k), mk(0, 32'h0, 0, 3'b111, 2'b00, 2'd3, 0));
      else        check("to_err", mk(0, 32'h0, 0, 3'b000, 2'b00, 2'd3, 1));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("to_idle", mk(0, 32'h0, 0, 3'b111, 2'b00, 2'd0, 0));
    bus_hold_i = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("to_rel", mk(0, 32'h0, 0, 3'b000, 2'b00, 2'd3, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
